imm_encode: RTL and testbench
=============================

Name: imm_encode

Overview:
- Inverse of the decode-side immediate extraction. Takes a 32-bit immediate value, an instruction format and a base instruction word. Produces the full instruction word with the immediate bits scattered into the RISC-V format positions.
- Flags immediates that cannot be represented in the chosen format.
- Sits between the trace/patch generator and the instruction memory write port. Valid/ready on both sides, with a 2-entry output buffer.

Parameters:
- BUF_DEPTH, 2, output buffer entries; only 2 is supported.
- CNT_W, 8, width of the encoded-instruction counter.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- flush_i  in  1  synchronous clear of buffer contents; counters are kept
- v_i  in  1  input valid
- ready_o  out  1  input ready
- inst_type_i  in  rvga_inst_type  format selector (R/I/S/B/U/J)
- shift_v_i  in  1  I-type shift-amount form
- imm_i  in  32  immediate value (rvga_word)
- base_i  in  32  base instruction; supplies all non-immediate bits
- v_o  out  1  output valid
- ready_i  in  1  downstream ready
- inst_o  out  32  encoded instruction
- err_o  out  1  range error for the entry on inst_o
- enc_cnt_o  out  CNT_W  count of entries accepted, wrapping
- err_cnt_o  out  8  saturating error count (optional feature only)

Behaviour:
- Reset: buffer empty, v_o=0, inst_o=0, err_o=0, enc_cnt_o=0, err_cnt_o=0. ready_o=1 in the first cycle after reset deasserts.
- Clocking: clk_i drives all state. reset_i is synchronous, active-high, and overrides flush_i and all handshakes. Reset mid-stream discards buffered entries.
- Accept condition: v_i & ready_o. The encoding is computed combinationally from the inputs and written into the buffer tail.
- Latency: an entry accepted in cycle N is visible on v_o/inst_o in cycle N+1 if the buffer was empty.
- Handshakes: the buffer is a FIFO. ready_o = (count < 2) and is registered-state only, with no combinational path from ready_i. Pop condition: v_o & ready_i.
- Simultaneous push and pop: allowed when count is 1; count stays 1 and order is preserved. When count is 2, push is blocked by ready_o=0 even if a pop occurs in the same cycle.
- Output stability: inst_o/err_o hold stable while v_o=1 and ready_i=0. When v_o=0, they hold the last popped value.
- flush_i: empties the buffer next cycle and blocks any same-cycle push. enc_cnt_o does not count a flushed push.
- Encoding: every bit not listed below is taken from base_i.
  - I: inst[31:20]=imm[11:0].
  - I with shift_v_i: inst[24:20]=imm[4:0]; inst[31:25] is kept from base_i (funct7).
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
  - U: inst[31:12]=imm[31:12].
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
  - R or any other type: inst=base_i, err=0.
- Range check: err=1 when the immediate is not representable. On error the truncated encoding is still produced.
  - I, S: imm[31:11] not all equal.
  - Shift: imm[31:5] nonzero.
  - B: imm[0]=1, or imm[31:12] not all equal.
  - U: imm[11:0] nonzero.
  - J: imm[0]=1, or imm[31:20] not all equal.
- enc_cnt_o: increments by 1 per accepted entry and wraps at 2^CNT_W.

Optional Feature:
- Macro: RVGA_IMM_ENCODE_ERRCNT_EN.
- Defined: err_cnt_o increments on each accepted entry with err=1, saturates at 255 and clears only on reset_i. In simulation, an assertion fires if v_o=1 and inst_o changes while ready_i=0.
- Undefined: err_cnt_o is tied to 0, no counter flops, no assertion.

Test Plan:
- I-type, imm_i=0xFFFFF800, base_i=0x00000013, ready_i=1 -> next cycle v_o=1, inst_o=0x80000013, err_o=0, enc_cnt_o=1.
- B-type, imm_i=0x00000FFE, base_i=0x00000063 -> inst_o=0x7E000FE3, err_o=0. Repeat with imm_i=0x00000FFF -> err_o=1.
- Shift, imm_i=0x00000021, base_i=0x40005013 -> inst_o=0x40105013, err_o=1 (imm[5] set).
- Backpressure: ready_i=0, push 3 entries back-to-back -> ready_o=0 after the 2nd. Raise ready_i -> entries pop in order and the 3rd is accepted. inst_o holds stable while stalled.
- Push and pop in the same cycle with count=1 -> count remains 1 and output order is correct. flush_i with 2 buffered -> v_o=0 next cycle, enc_cnt_o unchanged.
- Reset mid-stream with 2 entries buffered -> next cycle v_o=0 and enc_cnt_o=0. With the macro defined: 300 error entries -> err_cnt_o=255.

Source files
------------

// File: rtl/imm_encode.sv
// imm_encode: scatters an immediate into a RISC-V instruction word and flags values the format cannot hold,
// behind a 2-entry valid/ready FIFO. Define RVGA_IMM_ENCODE_ERRCNT_EN for the saturating error counter.
package rvga_pkg;
   typedef logic [31:0] rvga_word;
   typedef enum logic [2:0] {INST_R, INST_I, INST_S, INST_B, INST_U, INST_J} rvga_inst_type;
endpackage

module imm_encode
   import rvga_pkg::*;
#(
   parameter int BUF_DEPTH = 2,
   parameter int CNT_W     = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             v_i,
   output logic             ready_o,
   input  rvga_inst_type    inst_type_i,
   input  logic             shift_v_i,
   input  rvga_word         imm_i,
   input  rvga_word         base_i,
   output logic             v_o,
   input  logic             ready_i,
   output logic [31:0]      inst_o,
   output logic             err_o,
   output logic [CNT_W-1:0] enc_cnt_o,
   output logic [7:0]       err_cnt_o
);
   logic [1:0]  count;
   logic [32:0] head, tail;
   logic [31:0] enc;
   logic        enc_err, push, pop;

   always_comb begin
      enc     = base_i;
      enc_err = 1'b0;
      case (inst_type_i)
         INST_I: begin
            enc     = shift_v_i ? {base_i[31:25], imm_i[4:0], base_i[19:0]} : {imm_i[11:0], base_i[19:0]};
            enc_err = shift_v_i ? |imm_i[31:5] : ~(&imm_i[31:11] | ~|imm_i[31:11]);
         end
         INST_S: begin
            enc     = {imm_i[11:5], base_i[24:12], imm_i[4:0], base_i[6:0]};
            enc_err = ~(&imm_i[31:11] | ~|imm_i[31:11]);
         end
         INST_B: begin
            enc     = {imm_i[12], imm_i[10:5], base_i[24:12], imm_i[4:1], imm_i[11], base_i[6:0]};
            enc_err = imm_i[0] | ~(&imm_i[31:12] | ~|imm_i[31:12]);
         end
         INST_U: begin
            enc     = {imm_i[31:12], base_i[11:0]};
            enc_err = |imm_i[11:0];
         end
         INST_J: begin
            enc     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], base_i[11:0]};
            enc_err = imm_i[0] | ~(&imm_i[31:20] | ~|imm_i[31:20]);
         end
         default: begin
            enc     = base_i;
            enc_err = 1'b0;
         end
      endcase
   end

   assign ready_o = count < 2'(BUF_DEPTH);
   assign v_o     = count != 2'd0;
   assign push    = v_i & ready_o & ~flush_i;
   assign pop     = v_o & ready_i;
   assign inst_o  = head[32:1];
   assign err_o   = head[0];

   // head doubles as the output register, so it keeps the last popped entry once the FIFO drains
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count     <= 2'd0;
         head      <= '0;
         tail      <= '0;
         enc_cnt_o <= '0;
      end else begin
         if (flush_i) count <= 2'd0;
         else begin
            count <= count + 2'(push) - 2'(pop);
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) head <= {enc, enc_err};
            else if (pop && count == 2'd2) head <= tail;
            if (push && count == 2'd1 && !pop) tail <= {enc, enc_err};
         end
         if (push) enc_cnt_o <= enc_cnt_o + CNT_W'(1);
      end
   end

`ifdef RVGA_IMM_ENCODE_ERRCNT_EN
   logic [7:0] err_cnt;
   always_ff @(posedge clk_i) begin
      if (reset_i) err_cnt <= 8'd0;
      else if (push && enc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end
   assign err_cnt_o = err_cnt;
   stall_stable: assert property (@(posedge clk_i) disable iff (reset_i) v_o && !ready_i |=> $stable(inst_o));
`else
   assign err_cnt_o = 8'd0;
`endif
endmodule

// File: tb/tb_imm_encode.sv
// tb_imm_encode: directed vectors with a queue scoreboard and a decoupled output monitor.
module tb_imm_encode;
   import rvga_pkg::*;
   logic          clk_i = 0, reset_i = 1, flush_i = 0, v_i = 0, ready_i = 1, shift_v_i = 0;
   rvga_inst_type inst_type_i = INST_R;
   logic [31:0]   imm_i = 0, base_i = 0;
   logic          ready_o, v_o, err_o;
   logic [31:0]   inst_o;
   logic [7:0]    enc_cnt_o, err_cnt_o;
   logic [32:0]   sb[$];
   logic [32:0]   mexp;
   logic [7:0]    cnt_save;
   int            checks = 0, errors = 0;
   bit            c_done;

   imm_encode #(.BUF_DEPTH(2), .CNT_W(8)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .v_i(v_i), .ready_o(ready_o),
      .inst_type_i(inst_type_i), .shift_v_i(shift_v_i), .imm_i(imm_i), .base_i(base_i),
      .v_o(v_o), .ready_i(ready_i), .inst_o(inst_o), .err_o(err_o),
      .enc_cnt_o(enc_cnt_o), .err_cnt_o(err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (!reset_i && v_o && ready_i) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected got inst=%h err=%b", inst_o, err_o);
         end else begin
            mexp = sb.pop_front();
            if ({inst_o, err_o} !== mexp) begin
               errors++;
               $display("FAIL out_entry got inst=%h err=%b exp inst=%h err=%b", inst_o, err_o, mexp[32:1], mexp[0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, act, exp);
      end
   endtask

   task automatic send(input rvga_inst_type t, input logic sh, input logic [31:0] imm, input logic [31:0] base,
                       input logic [31:0] exp_inst, input logic exp_err);
      int n = 0;
      inst_type_i = t; shift_v_i = sh; imm_i = imm; base_i = base; v_i = 1;
      @(negedge clk_i);
      while (!ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got ready_o=0 exp 1");
      end else sb.push_back({exp_inst, exp_err});
      @(posedge clk_i);
      #1 v_i = 0;
   endtask

   task automatic do_reset();
      reset_i = 1;
      repeat (2) @(posedge clk_i);
      #1 reset_i = 0;
      sb.delete();
   endtask

   initial begin
      do_reset();
      @(negedge clk_i);
      chk("rst_v_o", 32'(v_o), 0);
      chk("rst_inst_o", inst_o, 0);
      chk("rst_err_o", 32'(err_o), 0);
      chk("rst_enc_cnt", 32'(enc_cnt_o), 0);
      chk("rst_err_cnt", 32'(err_cnt_o), 0);
      chk("rst_ready_o", 32'(ready_o), 1);
      @(posedge clk_i); #1;
      send(INST_I, 0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 0);
      @(negedge clk_i);
      chk("lat_v_o", 32'(v_o), 1);
      chk("lat_enc_cnt", 32'(enc_cnt_o), 1);
      @(posedge clk_i); #1;
      send(INST_B, 0, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 0);
      send(INST_B, 0, 32'h00000FFF, 32'h00000063, 32'h7E000FE3, 1);
      send(INST_I, 1, 32'h00000021, 32'h40005013, 32'h40105013, 1);
      send(INST_S, 0, 32'hFFFFFFFF, 32'h00000023, 32'hFE000FA3, 0);
      send(INST_S, 0, 32'h00000800, 32'h00000023, 32'h80000023, 1);
      send(INST_U, 0, 32'h12345000, 32'h00000037, 32'h12345037, 0);
      send(INST_U, 0, 32'h12345678, 32'h00000037, 32'h12345037, 1);
      send(INST_J, 0, 32'h00000800, 32'h0000006F, 32'h0010006F, 0);
      send(INST_J, 0, 32'hFFFFFFFE, 32'h000000EF, 32'hFFFFF0EF, 0);
      send(INST_J, 0, 32'h00100000, 32'h0000006F, 32'h8000006F, 1);
      send(INST_R, 0, 32'hFFFFFFFF, 32'h00B50533, 32'h00B50533, 0);
      send(INST_I, 0, 32'h000007FF, 32'h00000013, 32'h7FF00013, 0);
      send(INST_I, 0, 32'h00000800, 32'h00000013, 32'h80000013, 1);
      repeat (2) @(posedge clk_i); #1;
      chk("cnt_after_vectors", 32'(enc_cnt_o), 14);
      // backpressure: two fill the FIFO, the third waits for a pop
      ready_i = 0;
      send(INST_U, 0, 32'hAAAAA000, 32'h00000037, 32'hAAAAA037, 0);
      send(INST_U, 0, 32'hBBBBB000, 32'h00000037, 32'hBBBBB037, 0);
      @(negedge clk_i);
      chk("bp_ready_o", 32'(ready_o), 0);
      chk("bp_v_o", 32'(v_o), 1);
      @(posedge clk_i); #1;
      c_done = 0;
      fork
         begin
            send(INST_U, 0, 32'hCCCCC000, 32'h00000037, 32'hCCCCC037, 0);
            c_done = 1;
         end
      join_none
      repeat (3) begin
         @(negedge clk_i);
         chk("bp_stable", inst_o, 32'hAAAAA037);
      end
      @(posedge clk_i); #1 ready_i = 1;
      for (int n = 0; n < 50 && !c_done; n++) @(posedge clk_i);
      chk("bp_third_accepted", 32'(c_done), 1);
      repeat (4) @(posedge clk_i); #1;
      chk("bp_drained_v_o", 32'(v_o), 0);
      // push and pop in the same cycle at count 1
      send(INST_U, 0, 32'h11111000, 32'h00000037, 32'h11111037, 0);
      send(INST_U, 0, 32'h22222000, 32'h00000037, 32'h22222037, 0);
      @(negedge clk_i);
      chk("pp_v_o", 32'(v_o), 1);
      chk("pp_inst_o", inst_o, 32'h22222037);
      @(negedge clk_i);
      chk("pp_empty", 32'(v_o), 0);
      // flush with two buffered and a blocked push
      @(posedge clk_i); #1 ready_i = 0;
      send(INST_U, 0, 32'h33333000, 32'h00000037, 32'h33333037, 0);
      send(INST_U, 0, 32'h44444000, 32'h00000037, 32'h44444037, 0);
      cnt_save = enc_cnt_o;
      flush_i = 1; v_i = 1; sb.delete();
      @(posedge clk_i); #1 flush_i = 0; v_i = 0;
      @(negedge clk_i);
      chk("flush_v_o", 32'(v_o), 0);
      chk("flush_enc_cnt", 32'(enc_cnt_o), 32'(cnt_save));
      // reset mid-stream
      @(posedge clk_i); #1;
      send(INST_U, 0, 32'h55555000, 32'h00000037, 32'h55555037, 0);
      send(INST_U, 0, 32'h66666000, 32'h00000037, 32'h66666037, 0);
      do_reset();
      @(negedge clk_i);
      chk("midrst_v_o", 32'(v_o), 0);
      chk("midrst_enc_cnt", 32'(enc_cnt_o), 0);
      chk("midrst_err_cnt", 32'(err_cnt_o), 0);
      @(posedge clk_i); #1 ready_i = 1;
`ifdef RVGA_IMM_ENCODE_ERRCNT_EN
      for (int k = 0; k < 300; k++) send(INST_U, 0, 32'h00000001, 32'h00000037, 32'h00000037, 1);
      repeat (3) @(posedge clk_i); #1;
      chk("err_cnt_sat", 32'(err_cnt_o), 255);
      chk("enc_cnt_wrap", 32'(enc_cnt_o), 300 - 256);
`else
      send(INST_U, 0, 32'h00000001, 32'h00000037, 32'h00000037, 1);
      repeat (3) @(posedge clk_i); #1;
      chk("err_cnt_tied", 32'(err_cnt_o), 0);
`endif
      chk("sb_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
